ni_inject: RTL

Local-port injection interface that sits directly upstream of the router's L input. It takes core send requests (destination mask and payload), buffers them, and builds 30-bit flits. Each flit goes onto L_data_in/L_valid_in under control of the router's L-port full signal. Self-addressed destinations go to a local loopback port. Multicast requests are either sent as one multicast flit or split into unicast flits, selected by parameter.

---
 rtl/ni_pkg.sv | 31 +++
 rtl/ni_req_fifo.sv | 58 +++++
 rtl/ni_inject.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/ni_pkg.sv
// Shared definitions for the local-port injection interface:
// flit field offsets, FSM encoding and destination-mask helpers.
package ni_pkg;

    localparam int NODES   = 16;
    localparam int SEQ_W   = 4;

    localparam int MC_BIT  = 0;
    localparam int DST_LSB = 1;
    localparam int DST_MSB = 16;
    localparam int SRC_LSB = 17;
    localparam int SRC_MSB = 20;
    localparam int SEQ_LSB = 21;
    localparam int SEQ_MSB = 24;
    localparam int PAY_LSB = 25;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SEND  = 2'd1,
        S_SPLIT = 2'd2
    } ni_state_e;

    function automatic logic [NODES-1:0] lowbit(input logic [NODES-1:0] m);
        return m & (~m + 1'b1);
    endfunction

    function automatic logic multi(input logic [NODES-1:0] m);
        return (m & (m - 1'b1)) != '0;
    endfunction

endpackage

// File: rtl/ni_req_fifo.sv
// Request queue for the injection interface; head is readable
// combinationally so the FSM can inspect it before popping.
module ni_req_fifo
    import ni_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2,
    parameter int DW    = NODES + SEQ_W + 5
)(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [DW-1:0]    i_data,
    output logic [DW-1:0]    o_head,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH:0]   o_count
);

    logic [DW-1:0]    r_mem [DEPTH];
    logic [WIDTH-1:0] r_wp;
    logic [WIDTH-1:0] r_rp;
    logic [WIDTH:0]   r_cnt;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_cnt == (WIDTH+1)'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign o_head  = r_mem[r_rp];
    assign o_count = r_cnt;
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (w_push)
            r_mem[r_wp] <= i_data;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push)
                r_wp <= r_wp + 1'b1;
            if (w_pop)
                r_rp <= r_rp + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/ni_inject.sv
// Local-port injection interface: queues core send requests and
// turns them into router flits, with loopback for self-addressed bits.
module ni_inject
    import ni_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int WIDTH     = 2,
    parameter int DATASIZE  = 30,
    parameter int router_ID = 6,
    parameter int MC_EN     = 1
)(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [NODES-1:0]    req_mask,
    input  logic [DATASIZE-26:0] req_payload,
    input  logic                router_full,
    output logic [DATASIZE-1:0] inj_data,
    output logic                inj_valid,
    output logic [DATASIZE-1:0] lb_data,
    output logic                lb_valid,
    output logic [7:0]          drop_cnt
);

    localparam int PW = DATASIZE - 25;
    localparam int DW = NODES + SEQ_W + PW;
    localparam logic [NODES-1:0] SELF = NODES'(1) << router_ID;
    localparam logic [3:0]       SRC  = 4'(router_ID);

    ni_state_e           r_state;
    logic [SEQ_W-1:0]    r_seq;
    logic [7:0]          r_drop;
    logic [NODES-1:0]    r_rem;
    logic                r_lbp;
    logic                r_inj_v;
    logic [DATASIZE-1:0] r_inj_d;
    logic                r_lb_v;
    logic [DATASIZE-1:0] r_lb_d;

    logic                w_full;
    logic                w_empty;
    logic [WIDTH:0]      w_count;
    logic                w_accept;
    logic                w_push;
    logic                w_drop;
    logic                w_pop;
    logic                w_more;
    logic [DW-1:0]       w_wdata;
    logic [DW-1:0]       w_head;
    logic [NODES-1:0]    w_hmask;
    logic [SEQ_W-1:0]    w_hseq;
    logic [PW-1:0]       w_hpay;
    logic [NODES-1:0]    w_rem0;
    logic [NODES-1:0]    w_low;
    logic                w_self;
    logic [DATASIZE-1:0] w_lb_flit;

    function automatic logic [DATASIZE-1:0] mk_flit(
        input logic [NODES-1:0] m,
        input logic [SEQ_W-1:0] s,
        input logic [PW-1:0]    p
    );
        logic [DATASIZE-1:0] f;
        f                  = '0;
        f[MC_BIT]          = multi(m);
        f[DST_MSB:DST_LSB] = m;
        f[SRC_MSB:SRC_LSB] = SRC;
        f[SEQ_MSB:SEQ_LSB] = s;
        f[DATASIZE-1:PAY_LSB] = p;
        return f;
    endfunction

    assign w_accept  = req_valid && !w_full;
    assign w_push    = w_accept && (req_mask != '0);
    assign w_drop    = w_accept && (req_mask == '0);
    assign w_wdata   = {req_mask, r_seq, req_payload};
    assign w_hmask   = w_head[DW-1 -: NODES];
    assign w_hseq    = w_head[PW +: SEQ_W];
    assign w_hpay    = w_head[PW-1:0];
    assign w_rem0    = w_hmask & ~SELF;
    assign w_self    = |(w_hmask & SELF);
    assign w_low     = lowbit(r_rem);
    assign w_lb_flit = mk_flit(w_hmask, w_hseq, w_hpay);
    // Queue stays non-empty after this edge's pop
    assign w_more    = (w_count > (WIDTH+1)'(1)) || w_push;

    assign req_ready = !w_full;
    assign inj_valid = r_inj_v;
    assign inj_data  = r_inj_d;
    assign lb_valid  = r_lb_v;
    assign lb_data   = r_lb_d;
    assign drop_cnt  = r_drop;

    ni_req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .DW    (DW)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_wdata),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_comb begin
        w_pop = 1'b0;
        case (r_state)
            S_SEND: begin
                if (w_rem0 == '0)
                    w_pop = 1'b1;
                else if (((MC_EN != 0) || !multi(w_rem0)) && !router_full)
                    w_pop = 1'b1;
            end
            S_SPLIT: begin
                if (!router_full && !multi(r_rem))
                    w_pop = 1'b1;
            end
            default: w_pop = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_state <= S_IDLE;
            r_seq   <= '0;
            r_drop  <= '0;
            r_rem   <= '0;
            r_lbp   <= 1'b0;
            r_inj_v <= 1'b0;
            r_inj_d <= '0;
            r_lb_v  <= 1'b0;
            r_lb_d  <= '0;
        end else begin
            r_inj_v <= 1'b0;
            r_lb_v  <= 1'b0;
            if (w_push)
                r_seq <= r_seq + 1'b1;
            if (w_drop && (r_drop != 8'hFF))
                r_drop <= r_drop + 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (!w_empty)
                        r_state <= S_SEND;
                end
                S_SEND: begin
                    if (w_rem0 == '0) begin
                        // Self-only request: loopback never waits on the router
                        r_lb_v  <= 1'b1;
                        r_lb_d  <= w_lb_flit;
                        r_state <= w_more ? S_SEND : S_IDLE;
                    end else if ((MC_EN != 0) || !multi(w_rem0)) begin
                        if (!router_full) begin
                            r_inj_v <= 1'b1;
                            r_inj_d <= mk_flit(w_rem0, w_hseq, w_hpay);
                            if (w_self) begin
                                r_lb_v <= 1'b1;
                                r_lb_d <= w_lb_flit;
                            end
                            r_state <= w_more ? S_SEND : S_IDLE;
                        end
                    end else begin
                        r_rem   <= w_rem0;
                        r_lbp   <= w_self;
                        r_state <= S_SPLIT;
                    end
                end
                S_SPLIT: begin
                    if (!router_full) begin
                        r_inj_v <= 1'b1;
                        r_inj_d <= mk_flit(w_low, w_hseq, w_hpay);
                        r_rem   <= r_rem & ~w_low;
                        if (r_lbp) begin
                            r_lb_v <= 1'b1;
                            r_lb_d <= w_lb_flit;
                            r_lbp  <= 1'b0;
                        end
                        if (!multi(r_rem))
                            r_state <= w_more ? S_SEND : S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
